// File: rtl/qa_drv_hc_mc_status_pkg.sv
// Shared types, CTRL frame offsets and line pack/unpack helpers for the
// multi-channel host-channel status manager.
package qa_drv_hc_mc_status_pkg;

  localparam int unsigned MC_MAX_CHANNELS = 8;
  localparam int unsigned MC_WORD_W       = 32;
  localparam int unsigned MC_LINE_W       = 512;

  // CTRL frame line offsets relative to the 4KB-aligned base
  localparam logic [31:0] CTRL_OFF_CFG        = 32'd0;
  localparam logic [31:0] CTRL_OFF_FIFO_STATE = 32'd1;
  localparam logic [31:0] CTRL_OFF_POLL_STATE = 32'd2;

  typedef enum logic [1:0] {
    RD_GAP  = 2'd0,
    RD_POLL = 2'd1,
    RD_WAIT = 2'd2
  } t_rd_state;

  typedef enum logic {
    WR_INIT   = 1'b0,
    WR_ACTIVE = 1'b1
  } t_wr_state;

  // One zero-extended index word, and one word per possible channel
  typedef logic [MC_WORD_W-1:0]                t_mc_idx;
  typedef t_mc_idx [MC_MAX_CHANNELS-1:0]       t_mc_idx_vec;
  typedef logic [MC_LINE_W-1:0]                t_mc_line;

  // Channel c: from-host index in word 2c, to-host index in word 2c+1
  function automatic t_mc_line mc_pack_fifo_state(input t_mc_idx_vec fh,
                                                  input t_mc_idx_vec th,
                                                  input int unsigned n);
    t_mc_line line;
    line = '0;
    for (int unsigned c = 0; c < MC_MAX_CHANNELS; c++) begin
      if (c < n) begin
        line[(2*c)*MC_WORD_W   +: MC_WORD_W] = fh[c];
        line[(2*c+1)*MC_WORD_W +: MC_WORD_W] = th[c];
      end
    end
    return line;
  endfunction

  function automatic t_mc_idx_vec mc_unpack_fh(input t_mc_line line);
    t_mc_idx_vec v;
    for (int unsigned c = 0; c < MC_MAX_CHANNELS; c++)
      v[c] = line[(2*c)*MC_WORD_W +: MC_WORD_W];
    return v;
  endfunction

  function automatic t_mc_idx_vec mc_unpack_th(input t_mc_line line);
    t_mc_idx_vec v;
    for (int unsigned c = 0; c < MC_MAX_CHANNELS; c++)
      v[c] = line[(2*c+1)*MC_WORD_W +: MC_WORD_W];
    return v;
  endfunction

  // CFG line: channel count, then the all-ones index mask for both directions
  function automatic t_mc_line mc_pack_cfg(input int unsigned n,
                                           input int unsigned idx_w);
    t_mc_line line;
    line = '0;
    line[31:0]  = 32'(n);
    line[63:32] = (32'd1 << idx_w) - 32'd1;
    line[95:64] = (32'd1 << idx_w) - 32'd1;
    return line;
  endfunction

endpackage

// File: rtl/qa_drv_hc_mc_status_poller.sv
// Poll reader: paces POLL_STATE reads, times out lost responses, publishes
// the host-written per-channel indices and counts dropped responses.
module qa_drv_hc_mc_status_poller
  import qa_drv_hc_mc_status_pkg::*;
#(
  parameter int unsigned N_CHANNELS = 1,
  parameter int unsigned IDX_W      = 9,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned RD_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   ctrl_base,
  input  logic                          ctrl_valid,
  output logic                          rd_req,
  output logic [31:0]                   rd_addr,
  input  logic                          rd_grant,
  input  logic                          rd_rsp_valid,
  input  logic [511:0]                  rd_rsp_data,
  output logic [N_CHANNELS*IDX_W-1:0]   fh_newest_idx,
  output logic [N_CHANNELS*IDX_W-1:0]   th_oldest_idx,
  output logic [15:0]                   stale_rsp_cnt
);

  localparam int unsigned    GAP_W    = $clog2(POLL_GAP + 1);
  localparam int unsigned    TMO_W    = $clog2(RD_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

  t_rd_state        state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  t_mc_idx_vec      rsp_fh, rsp_th;
  logic             rsp_take;
  logic             rsp_stale;

  assign rsp_take  = rd_rsp_valid && (state_q == RD_WAIT);
  assign rsp_stale = rd_rsp_valid && (state_q != RD_WAIT);
  assign rsp_fh    = mc_unpack_fh(rd_rsp_data);
  assign rsp_th    = mc_unpack_th(rd_rsp_data);

  // Reader state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RD_GAP;
    else          state_q <= state_d;
  end

  // Reader next state; an unprogrammed CTRL frame parks the reader in POLL
  always_comb begin
    state_d = state_q;
    if (!ctrl_valid) begin
      state_d = RD_POLL;
    end else begin
      unique case (state_q)
        RD_GAP:  if (gap_cnt_q == GAP_LAST) state_d = RD_POLL;
        RD_POLL: if (rd_grant)              state_d = RD_WAIT;
        RD_WAIT: begin
          if (rd_rsp_valid)                 state_d = RD_GAP;
          else if (tmo_cnt_q == TMO_LAST)   state_d = RD_POLL;
        end
        default:                            state_d = RD_GAP;
      endcase
    end
  end

  // Reader outputs; address is only driven while requesting
  always_comb begin
    rd_req  = (state_q == RD_POLL) && ctrl_valid;
    rd_addr = rd_req ? (ctrl_base | CTRL_OFF_POLL_STATE) : '0;
  end

  // Gap and timeout counters restart whenever their state is re-entered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gap_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      gap_cnt_q <= (state_q == RD_GAP)  ? gap_cnt_q + GAP_W'(1) : '0;
      tmo_cnt_q <= (state_q == RD_WAIT) ? tmo_cnt_q + TMO_W'(1) : '0;
    end
  end

  // Publish response indices and count responses that arrive out of WAIT
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fh_newest_idx <= '0;
      th_oldest_idx <= '0;
      stale_rsp_cnt <= '0;
    end else begin
      if (rsp_take) begin
        for (int unsigned c = 0; c < N_CHANNELS; c++) begin
          fh_newest_idx[c*IDX_W +: IDX_W] <= rsp_fh[c][IDX_W-1:0];
          th_oldest_idx[c*IDX_W +: IDX_W] <= rsp_th[c][IDX_W-1:0];
        end
      end
      if (rsp_stale && (stale_rsp_cnt != 16'hFFFF))
        stale_rsp_cnt <= stale_rsp_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/qa_drv_hc_mc_status_manager.sv
// Multi-channel host-channel status manager: polls the CTRL poll line via
// the poller and writes CFG / per-channel FIFO state back to CTRL.
module qa_drv_hc_mc_status_manager
  import qa_drv_hc_mc_status_pkg::*;
#(
  parameter int unsigned N_CHANNELS   = 1,
  parameter int unsigned IDX_W        = 9,
  parameter int unsigned MONITOR_BIT  = 6,
  parameter int unsigned POLL_GAP     = 16,
  parameter int unsigned RD_TIMEOUT   = 1024,
  parameter int unsigned FLUSH_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   ctrl_base,
  input  logic                          ctrl_valid,
  input  logic                          enable_test,
  output logic                          rd_req,
  output logic [31:0]                   rd_addr,
  input  logic                          rd_grant,
  input  logic                          rd_rsp_valid,
  input  logic [511:0]                  rd_rsp_data,
  output logic                          wr_req,
  output logic [31:0]                   wr_addr,
  output logic [511:0]                  wr_data,
  input  logic                          wr_grant,
  input  logic [N_CHANNELS*IDX_W-1:0]   fh_oldest_idx,
  input  logic [N_CHANNELS*IDX_W-1:0]   th_next_idx,
  output logic [N_CHANNELS*IDX_W-1:0]   fh_newest_idx,
  output logic [N_CHANNELS*IDX_W-1:0]   th_oldest_idx,
  output logic [15:0]                   stale_rsp_cnt
);

  localparam int unsigned      NW       = N_CHANNELS * IDX_W;
  localparam int unsigned      AGE_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(FLUSH_CYCLES);
  localparam t_mc_line         CFG_LINE = mc_pack_cfg(N_CHANNELS, IDX_W);

  qa_drv_hc_mc_status_poller #(
    .N_CHANNELS (N_CHANNELS),
    .IDX_W      (IDX_W),
    .POLL_GAP   (POLL_GAP),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_poller (
    .clk           (clk),
    .reset_n       (reset_n),
    .ctrl_base     (ctrl_base),
    .ctrl_valid    (ctrl_valid),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_grant      (rd_grant),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data),
    .fh_newest_idx (fh_newest_idx),
    .th_oldest_idx (th_oldest_idx),
    .stale_rsp_cnt (stale_rsp_cnt)
  );

  t_wr_state        wr_state_q, wr_state_d;
  logic [NW-1:0]    fh_q, th_q;
  logic [NW-1:0]    fh_snap, th_snap;
  logic [NW-1:0]    fh_last, th_last;
  logic             en_test_q;
  logic [AGE_W-1:0] age_q;
  t_mc_idx_vec      fh_vec, th_vec;
  logic             fh_diff, th_diff, mon_diff;
  logic             need_update, reinit, write_done;
  logic             wr_req_d;
  logic [31:0]      wr_addr_d;
  logic [511:0]     wr_data_d;
  logic             snap_load, last_load;

  // Register index inputs and the enable_test level for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fh_q      <= '0;
      th_q      <= '0;
      en_test_q <= 1'b0;
    end else begin
      fh_q      <= fh_oldest_idx;
      th_q      <= th_next_idx;
      en_test_q <= enable_test;
    end
  end

  // Compare registered indices against the last values written to CTRL
  always_comb begin
    fh_vec   = '0;
    th_vec   = '0;
    mon_diff = 1'b0;
    for (int unsigned c = 0; c < N_CHANNELS; c++) begin
      fh_vec[c][IDX_W-1:0] = fh_q[c*IDX_W +: IDX_W];
      th_vec[c][IDX_W-1:0] = th_q[c*IDX_W +: IDX_W];
      if (fh_q[c*IDX_W + MONITOR_BIT] != fh_last[c*IDX_W + MONITOR_BIT])
        mon_diff = 1'b1;
    end
    fh_diff     = (fh_q != fh_last);
    th_diff     = (th_q != th_last);
    need_update = (wr_state_q == WR_ACTIVE) &&
                  (mon_diff || th_diff || (fh_diff && (age_q >= AGE_MAX)));
    // A level check on ctrl_valid also covers a fall coinciding with INIT's grant
    reinit      = (enable_test && !en_test_q) || !ctrl_valid;
    write_done  = wr_req && wr_grant;
  end

  // Age of unsent from-host progress; saturates, restarts on each grant
  always_ff @(posedge clk) begin
    if (!reset_n)                                   age_q <= '0;
    else if (write_done && wr_state_q == WR_ACTIVE) age_q <= '0;
    else if (!fh_diff)                              age_q <= '0;
    else if (age_q < AGE_MAX)                       age_q <= age_q + AGE_W'(1);
  end

  // Writer state register
  always_ff @(posedge clk) begin
    if (!reset_n) wr_state_q <= WR_INIT;
    else          wr_state_q <= wr_state_d;
  end

  // Writer next state
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WR_INIT:   if (write_done && ctrl_valid) wr_state_d = WR_ACTIVE;
      WR_ACTIVE: if (reinit)                   wr_state_d = WR_INIT;
      default:                                 wr_state_d = WR_INIT;
    endcase
  end

  // Writer outputs: a request is loaded once and held unchanged until granted
  always_comb begin
    wr_req_d  = wr_req;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    snap_load = 1'b0;
    last_load = 1'b0;
    unique case (wr_state_q)
      WR_INIT: begin
        if (!ctrl_valid || write_done) begin
          wr_req_d = 1'b0;
        end else if (!wr_req) begin
          wr_req_d  = 1'b1;
          wr_addr_d = ctrl_base | CTRL_OFF_CFG;
          wr_data_d = CFG_LINE;
        end
      end
      WR_ACTIVE: begin
        if (write_done) begin
          wr_req_d  = 1'b0;
          last_load = 1'b1;
        end else if (reinit) begin
          wr_req_d  = 1'b0;
        end else if (!wr_req && need_update) begin
          wr_req_d  = 1'b1;
          wr_addr_d = ctrl_base | CTRL_OFF_FIFO_STATE;
          wr_data_d = mc_pack_fifo_state(fh_vec, th_vec, N_CHANNELS);
          snap_load = 1'b1;
        end
      end
      default: wr_req_d = 1'b0;
    endcase
  end

  // Write request registers, snapshot and last-written bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      fh_snap <= '0;
      th_snap <= '0;
      fh_last <= '0;
      th_last <= '0;
    end else begin
      wr_req  <= wr_req_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      if (snap_load) begin
        fh_snap <= fh_q;
        th_snap <= th_q;
      end
      if (last_load) begin
        fh_last <= fh_snap;
        th_last <= th_snap;
      end
    end
  end

endmodule
